// File: rtl/decode_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_if : fetch-FIFO pop side and 4-wide decoded-bundle side
// Rev 1.0
// ----------------------------------------------------------------------------
interface decode_stage_if #(
  parameter int DATA_WIDTH         = 128,
  parameter int DECODE_ISSUE_WIDTH = 4
);
  localparam int W = DECODE_ISSUE_WIDTH;

  logic                  fetch_rd_en;
  logic                  fetch_rd_valid;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic [40:0]           fetch_param;
  logic                  fetch_empty;
  logic                  ci_flush;

  logic                  dec_valid;
  logic                  dec_ready;
  logic [W-1:0]          dec_slot_valid;
  logic [40*W-1:0]       dec_pc;
  logic [4*W-1:0]        dec_op;
  logic [5*W-1:0]        dec_rd;
  logic [5*W-1:0]        dec_rs1;
  logic [5*W-1:0]        dec_rs2;
  logic [W-1:0]          dec_rd_we;
  logic [32*W-1:0]       dec_imm;
  logic [3*W-1:0]        dec_funct3;
  logic [W-1:0]          dec_alt;
  logic [W-1:0]          dec_illegal;
  logic                  dec_fault;

  modport master (
    output fetch_rd_en,
    input  fetch_rd_valid, fetch_instr, fetch_param, fetch_empty, ci_flush,
    output dec_valid,
    input  dec_ready,
    output dec_slot_valid, dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2,
    output dec_rd_we, dec_imm, dec_funct3, dec_alt, dec_illegal, dec_fault
  );

  modport slave (
    input  fetch_rd_en,
    output fetch_rd_valid, fetch_instr, fetch_param, fetch_empty, ci_flush,
    input  dec_valid,
    output dec_ready,
    input  dec_slot_valid, dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2,
    input  dec_rd_we, dec_imm, dec_funct3, dec_alt, dec_illegal, dec_fault
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage : pops RV32I fetch bundles, decodes all slots in parallel and
// registers the result for rename/dispatch.                          Rev 1.0
// ----------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_WIDTH         = 128,
  parameter int DECODE_ISSUE_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.master dec_if
);
  localparam int W      = DECODE_ISSUE_WIDTH;
  localparam int c_ilen = DATA_WIDTH / DECODE_ISSUE_WIDTH;

  localparam logic [3:0] c_op_none   = 4'd0;
  localparam logic [3:0] c_op_lui    = 4'd1;
  localparam logic [3:0] c_op_auipc  = 4'd2;
  localparam logic [3:0] c_op_jal    = 4'd3;
  localparam logic [3:0] c_op_jalr   = 4'd4;
  localparam logic [3:0] c_op_branch = 4'd5;
  localparam logic [3:0] c_op_load   = 4'd6;
  localparam logic [3:0] c_op_store  = 4'd7;
  localparam logic [3:0] c_op_imm    = 4'd8;
  localparam logic [3:0] c_op_op     = 4'd9;
  localparam logic [3:0] c_op_fence  = 4'd10;
  localparam logic [3:0] c_op_system = 4'd11;

  logic            valid_q,      valid_d;
  logic [W-1:0]    slot_valid_q, slot_valid_d;
  logic [40*W-1:0] pc_q,         pc_d;
  logic [4*W-1:0]  op_q,         op_d;
  logic [5*W-1:0]  rd_q,         rd_d;
  logic [5*W-1:0]  rs1_q,        rs1_d;
  logic [5*W-1:0]  rs2_q,        rs2_d;
  logic [W-1:0]    we_q,         we_d;
  logic [32*W-1:0] imm_q,        imm_d;
  logic [3*W-1:0]  f3_q,         f3_d;
  logic [W-1:0]    alt_q,        alt_d;
  logic [W-1:0]    ill_q,        ill_d;
  logic            fault_q,      fault_d;

  logic        w_rd_en;
  logic        w_accept;
  logic [35:0] w_pc_hi;
  logic [31:0] w_first;
  logic        w_fault;

  assign w_pc_hi = dec_if.fetch_param[40:5];
  assign w_first = {30'd0, dec_if.fetch_param[4:3]};
  assign w_fault = dec_if.fetch_param[0];
  assign fault_d = w_fault;

  // A flush blocks the pop so the FIFO head survives for the refetch path.
  assign w_rd_en  = rst_n & ~dec_if.fetch_empty & ~dec_if.ci_flush &
                    (~valid_q | dec_if.dec_ready);
  assign w_accept = w_rd_en & dec_if.fetch_rd_valid;

  for (genvar i = 0; i < W; i++) begin : g_slot
    logic [31:0] w_ins;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [3:0]  w_cls;
    logic [3:0]  w_op;
    logic        w_ill;
    logic        w_we;
    logic        w_sv;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;

    assign w_ins = dec_if.fetch_instr[c_ilen*i +: 32];
    assign w_f7  = w_ins[31:25];
    assign w_f3  = w_ins[14:12];

    always_comb begin
      w_cls = c_op_none;
      case (w_ins[6:0])
        7'b0110111: w_cls = c_op_lui;
        7'b0010111: w_cls = c_op_auipc;
        7'b1101111: w_cls = c_op_jal;
        7'b1100111: w_cls = c_op_jalr;
        7'b1100011: w_cls = c_op_branch;
        7'b0000011: w_cls = c_op_load;
        7'b0100011: w_cls = c_op_store;
        7'b0010011: w_cls = c_op_imm;
        7'b0110011: w_cls = c_op_op;
        7'b0001111: w_cls = c_op_fence;
        7'b1110011: w_cls = c_op_system;
        default:    w_cls = c_op_none;
      endcase

      w_ill = (w_cls == c_op_none);
      if (w_cls == c_op_op && w_f7 != 7'h00 &&
          !(w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)))
        w_ill = 1'b1;
      if (w_cls == c_op_imm && w_f3 == 3'd1 && w_f7 != 7'h00)
        w_ill = 1'b1;
      if (w_cls == c_op_imm && w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20)
        w_ill = 1'b1;

      w_imm = '0;
      case (w_ill ? c_op_none : w_cls)
        c_op_jalr, c_op_load, c_op_imm, c_op_system:
          w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
        c_op_store:
          w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        c_op_branch:
          w_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        c_op_lui, c_op_auipc:
          w_imm = {w_ins[31:12], 12'd0};
        c_op_jal:
          w_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
        default:
          w_imm = '0;
      endcase

      w_rd = w_ins[11:7];
      if (w_cls inside {c_op_branch, c_op_store, c_op_fence})
        w_rd = '0;
      w_rs1 = w_ins[19:15];
      if (w_cls inside {c_op_lui, c_op_auipc, c_op_jal})
        w_rs1 = '0;
      w_rs2 = '0;
      if (w_cls inside {c_op_branch, c_op_store, c_op_op})
        w_rs2 = w_ins[24:20];

      w_we = ~w_ill && (w_rd != 5'd0) &&
             (w_cls inside {c_op_lui, c_op_auipc, c_op_jal, c_op_jalr,
                            c_op_load, c_op_imm, c_op_op, c_op_system});
      w_op = w_ill ? c_op_none : w_cls;

      // A faulting bundle exposes only its entry slot, stripped of its op.
      if (w_fault) begin
        w_sv = (32'(i) == w_first);
        if (w_sv)
          w_op = c_op_none;
      end else begin
        w_sv = (32'(i) >= w_first);
      end
    end

    assign slot_valid_d[i]    = w_sv;
    assign pc_d[40*i +: 40]   = {w_pc_hi, 4'd0} + 40'(4*i);
    assign op_d[4*i +: 4]     = w_op;
    assign rd_d[5*i +: 5]     = w_rd;
    assign rs1_d[5*i +: 5]    = w_rs1;
    assign rs2_d[5*i +: 5]    = w_rs2;
    assign we_d[i]            = w_we;
    assign imm_d[32*i +: 32]  = w_imm;
    assign f3_d[3*i +: 3]     = w_f3;
    assign alt_d[i]           = w_ins[30];
    assign ill_d[i]           = w_ill;
  end

  always_comb begin
    valid_d = valid_q;
    if (dec_if.ci_flush)
      valid_d = 1'b0;
    else if (w_accept)
      valid_d = 1'b1;
    else if (dec_if.dec_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      slot_valid_q <= '0;
      pc_q         <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      we_q         <= '0;
      imm_q        <= '0;
      f3_q         <= '0;
      alt_q        <= '0;
      ill_q        <= '0;
      fault_q      <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (w_accept) begin
        slot_valid_q <= slot_valid_d;
        pc_q         <= pc_d;
        op_q         <= op_d;
        rd_q         <= rd_d;
        rs1_q        <= rs1_d;
        rs2_q        <= rs2_d;
        we_q         <= we_d;
        imm_q        <= imm_d;
        f3_q         <= f3_d;
        alt_q        <= alt_d;
        ill_q        <= ill_d;
        fault_q      <= fault_d;
      end
    end
  end

  assign dec_if.fetch_rd_en    = w_rd_en;
  assign dec_if.dec_valid      = valid_q;
  assign dec_if.dec_slot_valid = slot_valid_q;
  assign dec_if.dec_pc         = pc_q;
  assign dec_if.dec_op         = op_q;
  assign dec_if.dec_rd         = rd_q;
  assign dec_if.dec_rs1        = rs1_q;
  assign dec_if.dec_rs2        = rs2_q;
  assign dec_if.dec_rd_we      = we_q;
  assign dec_if.dec_imm        = imm_q;
  assign dec_if.dec_funct3     = f3_q;
  assign dec_if.dec_alt        = alt_q;
  assign dec_if.dec_illegal    = ill_q;
  assign dec_if.dec_fault      = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// tb_decode_stage: directed decode vector table plus hand-written
// streaming / backpressure / flush / reset sequences.
module tb_decode_stage;
  localparam int W = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [127:0] BASIC = {32'h00000013, 32'h00A00113, 32'h00208193, 32'h00500093};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_WIDTH(128), .DECODE_ISSUE_WIDTH(W)) bus ();
  decode_stage #(.DATA_WIDTH(128), .DECODE_ISSUE_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec_if(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string        name;
    logic [127:0] bundle;
    logic [39:0]  pc;
    logic         fault;
    int           slot;
    logic [3:0]   sv;
    logic [3:0]   op;
    logic [31:0]  imm;
    logic         we;
    logic         ill;
    logic         alt;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [127:0] b, input logic [39:0] pc, input logic f);
    bus.fetch_instr = b;
    bus.fetch_param = {pc, f};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [127:0] b, input logic [39:0] pc,
                              input logic f, input int s, input logic [3:0] sv,
                              input logic [3:0] op, input logic [31:0] imm, input logic we,
                              input logic ill, input logic alt, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v.name = n; v.bundle = b; v.pc = pc; v.fault = f; v.slot = s; v.sv = sv;
    v.op = op; v.imm = imm; v.we = we; v.ill = ill; v.alt = alt;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    return v;
  endfunction

  function automatic logic [127:0] s0(input logic [31:0] ins);
    return {NOP, NOP, NOP, ins};
  endfunction

  function automatic logic [39:0] pc_of(input int s);
    return bus.dec_pc[40*s +: 40];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name        bundle               pc        f  s  sv     op  imm           we ill alt rd rs1 rs2
    vecs.push_back(mk("zero",   s0(32'h00000000), 40'h10000, 0, 0, 4'hF, 0,  32'h0,        0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sub",    s0(32'h40208033), 40'h10000, 0, 0, 4'hF, 9,  32'h0,        0, 0, 1, 0, 1, 2));
    vecs.push_back(mk("beq",    s0(32'hFE000EE3), 40'h10000, 0, 0, 4'hF, 5,  32'hFFFFFFFC, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("jal",    s0(32'h0000106F), 40'h10000, 0, 0, 4'hF, 3,  32'h00001000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lui",    s0(32'h123452B7), 40'h10000, 0, 0, 4'hF, 1,  32'h12345000, 1, 0, 0, 5, 0, 0));
    vecs.push_back(mk("lw",     s0(32'hFF812303), 40'h10000, 0, 0, 4'hF, 6,  32'hFFFFFFF8, 1, 0, 1, 6, 2, 0));
    vecs.push_back(mk("sw",     s0(32'h0071A623), 40'h10000, 0, 0, 4'hF, 7,  32'h0000000C, 0, 0, 0, 0, 3, 7));
    vecs.push_back(mk("slli_bad", s0(32'h02009093), 40'h10000, 0, 0, 4'hF, 0, 32'h0,       0, 1, 0, 1, 1, 0));
    vecs.push_back(mk("srai",   s0(32'h4030D093), 40'h10000, 0, 0, 4'hF, 8,  32'h00000403, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk("sll_alt_bad", s0(32'h40209033), 40'h10000, 0, 0, 4'hF, 0, 32'h0,    0, 1, 1, 0, 1, 2));
    vecs.push_back(mk("midbundle", BASIC,         40'h10008, 0, 2, 4'hC, 8,  32'h0000000A, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk("fault",  BASIC,            40'h10000, 1, 0, 4'h1, 0,  32'h00000005, 1, 0, 0, 1, 0, 0));

    // Reset state
    rst_n = 1'b0;
    bus.fetch_rd_valid = 1'b1;
    bus.fetch_empty    = 1'b0;
    bus.ci_flush       = 1'b0;
    bus.dec_ready      = 1'b1;
    drive(BASIC, 40'h10000, 1'b0);
    #1;
    check("reset_rd_en", 64'(bus.fetch_rd_en), 64'd0);
    step();
    step();
    check("reset_valid", 64'(bus.dec_valid), 64'd0);
    check("reset_slot_valid", 64'(bus.dec_slot_valid), 64'd0);
    check("reset_pc0", 64'(pc_of(0)), 64'd0);
    check("reset_op", 64'(bus.dec_op), 64'd0);
    check("reset_imm0", 64'(bus.dec_imm[31:0]), 64'd0);
    check("reset_fault", 64'(bus.dec_fault), 64'd0);
    rst_n = 1'b1;

    // Basic decode
    step();
    check("basic_valid", 64'(bus.dec_valid), 64'd1);
    check("basic_sv", 64'(bus.dec_slot_valid), 64'hF);
    check("basic_op0", 64'(bus.dec_op[3:0]), 64'd8);
    check("basic_rd0", 64'(bus.dec_rd[4:0]), 64'd1);
    check("basic_rs1_0", 64'(bus.dec_rs1[4:0]), 64'd0);
    check("basic_imm0", 64'(bus.dec_imm[31:0]), 64'd5);
    check("basic_we0", 64'(bus.dec_rd_we[0]), 64'd1);
    check("basic_pc0", 64'(pc_of(0)), 64'h10000);
    check("basic_pc3", 64'(pc_of(3)), 64'h1000C);
    check("basic_imm1", 64'(bus.dec_imm[63:32]), 64'd2);
    check("basic_imm2", 64'(bus.dec_imm[95:64]), 64'd10);
    check("basic_imm3", 64'(bus.dec_imm[127:96]), 64'd0);
    check("basic_op123", 64'(bus.dec_op[15:4]), 64'h888);
    check("basic_we3", 64'(bus.dec_rd_we[3]), 64'd0);

    // Table-driven decode vectors, one accepted per cycle
    foreach (vecs[k]) begin
      vec_t v;
      int s;
      v = vecs[k];
      s = v.slot;
      drive(v.bundle, v.pc, v.fault);
      step();
      check({v.name, "_valid"}, 64'(bus.dec_valid), 64'd1);
      check({v.name, "_sv"}, 64'(bus.dec_slot_valid), 64'(v.sv));
      check({v.name, "_fault"}, 64'(bus.dec_fault), 64'(v.fault));
      check({v.name, "_pc"}, 64'(pc_of(s)), 64'({v.pc[39:4], 4'd0} + 40'(4*s)));
      check({v.name, "_op"}, 64'(bus.dec_op[4*s +: 4]), 64'(v.op));
      check({v.name, "_imm"}, 64'(bus.dec_imm[32*s +: 32]), 64'(v.imm));
      check({v.name, "_we"}, 64'(bus.dec_rd_we[s]), 64'(v.we));
      check({v.name, "_ill"}, 64'(bus.dec_illegal[s]), 64'(v.ill));
      check({v.name, "_alt"}, 64'(bus.dec_alt[s]), 64'(v.alt));
      check({v.name, "_rd"}, 64'(bus.dec_rd[5*s +: 5]), 64'(v.rd));
      check({v.name, "_rs1"}, 64'(bus.dec_rs1[5*s +: 5]), 64'(v.rs1));
      check({v.name, "_rs2"}, 64'(bus.dec_rs2[5*s +: 5]), 64'(v.rs2));
    end

    // Streaming: one bundle per cycle
    for (int k = 0; k < 8; k++) begin
      drive(BASIC, 40'h10000 + 40'(16*k), 1'b0);
      #1;
      check("stream_rd_en", 64'(bus.fetch_rd_en), 64'd1);
      step();
      check("stream_valid", 64'(bus.dec_valid), 64'd1);
      check("stream_pc", 64'(pc_of(0)), 64'(40'h10000 + 40'(16*k)));
    end

    // Backpressure
    bus.dec_ready = 1'b0;
    drive(BASIC, 40'h10080, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rd_en", 64'(bus.fetch_rd_en), 64'd0);
      step();
      check("bp_valid", 64'(bus.dec_valid), 64'd1);
      check("bp_pc", 64'(pc_of(0)), 64'h10070);
    end
    bus.dec_ready = 1'b1;
    #1;
    check("bp_release_rd_en", 64'(bus.fetch_rd_en), 64'd1);
    step();
    check("bp_release_pc", 64'(pc_of(0)), 64'h10080);

    // Flush with a valid bundle and a non-empty FIFO
    bus.ci_flush = 1'b1;
    drive(BASIC, 40'h10090, 1'b0);
    #1;
    check("flush_rd_en", 64'(bus.fetch_rd_en), 64'd0);
    step();
    check("flush_valid", 64'(bus.dec_valid), 64'd0);
    check("flush_pc_kept", 64'(pc_of(0)), 64'h10080);
    bus.ci_flush = 1'b0;
    #1;
    check("post_flush_rd_en", 64'(bus.fetch_rd_en), 64'd1);
    step();
    check("post_flush_valid", 64'(bus.dec_valid), 64'd1);
    check("post_flush_pc", 64'(pc_of(0)), 64'h10090);

    // Pop request without a valid head: nothing captured
    bus.fetch_rd_valid = 1'b0;
    drive(BASIC, 40'h100A0, 1'b0);
    #1;
    check("novalid_rd_en", 64'(bus.fetch_rd_en), 64'd1);
    step();
    check("novalid_valid", 64'(bus.dec_valid), 64'd0);
    check("novalid_pc", 64'(pc_of(0)), 64'h10090);
    bus.fetch_rd_valid = 1'b1;
    step();
    check("revalid_pc", 64'(pc_of(0)), 64'h100A0);

    // Empty FIFO: valid drops after hand-off
    bus.fetch_empty = 1'b1;
    #1;
    check("empty_rd_en", 64'(bus.fetch_rd_en), 64'd0);
    step();
    check("empty_valid", 64'(bus.dec_valid), 64'd0);

    // Asynchronous reset mid-stream
    bus.fetch_empty = 1'b0;
    step();
    check("pre_rst_valid", 64'(bus.dec_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.dec_valid), 64'd0);
    check("async_rst_sv", 64'(bus.dec_slot_valid), 64'd0);
    check("async_rst_pc", 64'(pc_of(0)), 64'd0);
    check("async_rst_rd_en", 64'(bus.fetch_rd_en), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(bus.dec_valid), 64'd1);
    check("post_rst_pc", 64'(pc_of(0)), 64'h100A0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
